// File: rtl/phosphor_pkg.sv
// Shared definitions for the phosphor ring scheduler: ring word layout,
// the FSM state type and the saturating luma subtract.
package phosphor_pkg;

    localparam int LUMA_MSB = 11;
    localparam int X_LSB    = 12;
    localparam int Y_LSB    = 22;
    localparam int WORD_W   = 32;

    typedef enum logic {
        FLUSH,
        RUN
    } state_t;

    function automatic logic [LUMA_MSB:0] sat_sub12(
        input logic [LUMA_MSB:0] a,
        input logic [LUMA_MSB:0] b
    );
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/phosphor_decay_unit.sv
// Combinational decay of the oldest ring word; a word whose luma reaches
// zero collapses to the all-zero "free slot" encoding.
module phosphor_decay_unit
    import phosphor_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [LUMA_MSB:0] decay_step,
    input  logic              decay_active,
    output logic [WORD_W-1:0] decayed
);

    logic [LUMA_MSB:0] luma_in;
    logic [LUMA_MSB:0] luma_out;

    always_comb begin
        luma_in  = word[LUMA_MSB:0];
        luma_out = decay_active ? sat_sub12(luma_in, decay_step) : luma_in;
        decayed  = (luma_out == '0) ? '0 : {word[WORD_W-1:X_LSB], luma_out};
    end

endmodule

// File: rtl/phosphor_ring_scheduler.sv
// Ring write-back scheduler: flushes the ring after reset, then merges,
// inserts or force-inserts held pixels into the decaying ring stream.
module phosphor_ring_scheduler
    import phosphor_pkg::*;
#(
    parameter int unsigned RING_LEN     = 1024,
    parameter int unsigned DECAY_PASSES = 4,
    parameter int unsigned STARVE_LIMIT = 2048,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic [LUMA_MSB:0] decay_step,
    input  logic [WORD_W-1:0] ring_shiftout,
    output logic [WORD_W-1:0] ring_shiftin,
    output logic              flushing,
    output logic [CNT_W-1:0]  drop_count
);

    localparam int unsigned CYC_W  = (RING_LEN > 1) ? $clog2(RING_LEN) : 1;
    localparam int unsigned PASS_W = (DECAY_PASSES > 1) ? $clog2(DECAY_PASSES) : 1;
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    state_t              state, state_nxt;
    logic [CYC_W-1:0]    cyc_cnt, cyc_nxt;
    logic [PASS_W-1:0]   pass_cnt, pass_nxt;
    logic                hold_valid, hold_valid_nxt;
    logic [WORD_W-1:0]   hold, hold_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [WORD_W-1:0]   ring_nxt;
    logic [CNT_W-1:0]    drop_nxt;

    logic                decay_active;
    logic [WORD_W-1:0]   r_word;
    logic                is_merge, is_free, is_starve, drain, accept;
    logic [LUMA_MSB:0]   hold_luma, r_luma, max_luma;

    assign decay_active = (pass_cnt == '0);

    phosphor_decay_unit u_decay (
        .word         (ring_shiftout),
        .decay_step   (decay_step),
        .decay_active (decay_active),
        .decayed      (r_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= FLUSH;
            cyc_cnt      <= '0;
            pass_cnt     <= '0;
            hold_valid   <= 1'b0;
            hold         <= '0;
            wait_cnt     <= '0;
            ring_shiftin <= '0;
            drop_count   <= '0;
        end else begin
            state        <= state_nxt;
            cyc_cnt      <= cyc_nxt;
            pass_cnt     <= pass_nxt;
            hold_valid   <= hold_valid_nxt;
            hold         <= hold_nxt;
            wait_cnt     <= wait_nxt;
            ring_shiftin <= ring_nxt;
            drop_count   <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cyc_nxt        = cyc_cnt;
        pass_nxt       = pass_cnt;
        hold_valid_nxt = hold_valid;
        hold_nxt       = hold;
        wait_nxt       = wait_cnt;
        drop_nxt       = drop_count;
        ring_nxt       = '0;
        in_ready       = 1'b0;
        drain          = 1'b0;
        accept         = 1'b0;
        flushing       = (state == FLUSH);

        hold_luma = hold[LUMA_MSB:0];
        r_luma    = r_word[LUMA_MSB:0];
        max_luma  = (hold_luma > r_luma) ? hold_luma : r_luma;

        is_merge  = hold_valid && (r_luma != '0)
                    && (r_word[WORD_W-1:X_LSB] == hold[WORD_W-1:X_LSB]);
        is_free   = hold_valid && (r_word == '0);
        is_starve = hold_valid && (wait_cnt == WAIT_W'(STARVE_LIMIT));

        case (state)
            FLUSH: begin
                if (cyc_cnt == CYC_W'(RING_LEN - 1)) begin
                    state_nxt = RUN;
                    cyc_nxt   = '0;
                    pass_nxt  = '0;
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end

            RUN: begin
                drain    = is_merge || is_free || is_starve;
                in_ready = !hold_valid || drain;
                accept   = in_valid && in_ready;

                if (is_merge) begin
                    ring_nxt = {hold[WORD_W-1:X_LSB], max_luma};
                end else if (is_free) begin
                    ring_nxt = hold;
                end else if (is_starve) begin
                    ring_nxt = hold;
                    if (drop_count != '1) drop_nxt = drop_count + 1'b1;
                end else begin
                    ring_nxt = r_word;
                end

                if (drain) begin
                    hold_valid_nxt = 1'b0;
                    wait_nxt       = '0;
                end else if (hold_valid && (wait_cnt != WAIT_W'(STARVE_LIMIT))) begin
                    wait_nxt = wait_cnt + 1'b1;
                end

                // A zero-luma pixel is consumed but never occupies the hold slot.
                if (accept) begin
                    wait_nxt = '0;
                    if (in_data[LUMA_MSB:0] != '0) begin
                        hold_nxt       = in_data;
                        hold_valid_nxt = 1'b1;
                    end
                end

                if (cyc_cnt == CYC_W'(RING_LEN - 1)) begin
                    cyc_nxt  = '0;
                    pass_nxt = (pass_cnt == PASS_W'(DECAY_PASSES - 1)) ? '0 : pass_cnt + 1'b1;
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end

            default: state_nxt = FLUSH;
        endcase
    end

endmodule

// File: tb/tb_phosphor_ring_scheduler.sv
// Scoreboard bench for phosphor_ring_scheduler: a cycle model predicts each
// ring write-back, which is queued at drive time and compared after the edge.
module tb_phosphor_ring_scheduler;

    localparam int RL = 1024;
    localparam int DP = 2;
    localparam int SL = 2048;
    localparam int CW = 16;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic [11:0]   decay_step;
    logic [31:0]   ring_shiftout;
    logic [31:0]   ring_shiftin;
    logic          flushing;
    logic [CW-1:0] drop_count;

    phosphor_ring_scheduler #(
        .RING_LEN     (RL),
        .DECAY_PASSES (DP),
        .STARVE_LIMIT (SL),
        .CNT_W        (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .decay_step    (decay_step),
        .ring_shiftout (ring_shiftout),
        .ring_shiftin  (ring_shiftin),
        .flushing      (flushing),
        .drop_count    (drop_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] expq[$];

    bit          m_run;
    int          m_flush;
    int          m_run_cyc;
    bit          m_hold_v;
    logic [31:0] m_hold;
    int          m_wait;
    int          m_drops;
    logic        obs_ready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] model_decay(input logic [31:0] w, input logic [11:0] st, input bit act);
        int l;
        l = int'(w[11:0]);
        if (act) begin
            l = l - int'(st);
            if (l < 0) l = 0;
        end
        if (l == 0) return 32'd0;
        return {w[31:12], 12'(l)};
    endfunction

    function automatic int model_pass();
        return (m_run_cyc / RL) % DP;
    endfunction

    task automatic do_reset();
        reset         = 1'b1;
        in_valid      = 1'($urandom);
        in_data       = $urandom;
        ring_shiftout = $urandom;
        decay_step    = 12'($urandom);
        @(posedge clock); #1;
        reset     = 1'b0;
        m_run     = 0;
        m_flush   = 0;
        m_run_cyc = 0;
        m_hold_v  = 0;
        m_wait    = 0;
        m_drops   = 0;
        expq.delete();
        check_eq("rst_shiftin", ring_shiftin, 32'd0);
        check_eq("rst_flushing", 32'(flushing), 32'd1);
        check_eq("rst_drops", 32'(drop_count), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd0);
    endtask

    // Entered at posedge+1; leaves at the next posedge+1.
    task automatic run_cycle(input logic v, input logic [31:0] d, input logic [31:0] so, input logic [11:0] st);
        logic [31:0] r;
        logic [31:0] e;
        logic [11:0] ml;
        bit mrg, fre, stv, drn, rdy;
        in_valid      = v;
        in_data       = d;
        ring_shiftout = so;
        decay_step    = st;
        mrg = 0; fre = 0; stv = 0; drn = 0; rdy = 0; e = 32'd0;
        if (m_run) begin
            r   = model_decay(so, st, model_pass() == 0);
            mrg = m_hold_v && (r != 0) && (r[31:12] == m_hold[31:12]);
            fre = m_hold_v && (r == 0);
            stv = m_hold_v && (m_wait == SL);
            drn = mrg || fre || stv;
            rdy = !m_hold_v || drn;
            ml  = (m_hold[11:0] > r[11:0]) ? m_hold[11:0] : r[11:0];
            if (mrg)            e = {m_hold[31:12], ml};
            else if (fre || stv) e = m_hold;
            else                 e = r;
        end
        expq.push_back(e);
        #3;
        obs_ready = in_ready;
        check_eq("in_ready", 32'(obs_ready), 32'(rdy));
        @(posedge clock); #1;
        if (m_run) begin
            if (stv && !mrg && !fre && m_drops < 65535) m_drops++;
            if (drn) begin
                m_hold_v = 0;
                m_wait   = 0;
            end else if (m_hold_v && m_wait < SL) begin
                m_wait++;
            end
            if (v && rdy) begin
                m_wait = 0;
                if (d[11:0] != 0) begin
                    m_hold   = d;
                    m_hold_v = 1;
                end
            end
            m_run_cyc++;
        end else begin
            m_flush++;
            if (m_flush == RL) begin
                m_run     = 1;
                m_run_cyc = 0;
            end
        end
        if (expq.size() == 0) check_eq("queue_empty", 32'd0, 32'd1);
        else check_eq("ring_shiftin", ring_shiftin, expq.pop_front());
        check_eq("flushing", 32'(flushing), 32'(!m_run));
        check_eq("drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    initial begin
        int n;
        clock         = 1'b0;
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        decay_step    = '0;
        ring_shiftout = '0;
        @(posedge clock); #1;
        do_reset();

        // Flush with garbage on every input.
        repeat (RL) run_cycle(1'($urandom), $urandom, $urandom, 12'($urandom));
        check_eq("flush_done", 32'(flushing), 32'd0);
        check_eq("ready_after_flush", 32'(in_ready), 32'd1);

        // New pixel into a free slot.
        run_cycle(1'b1, 32'h0040_2FFF, 32'd0, 12'd0);
        check_eq("t2_accept", 32'(obs_ready), 32'd1);
        run_cycle(1'b0, 32'd0, 32'd0, 12'd0);
        check_eq("t2_write", ring_shiftin, 32'h0040_2FFF);

        // Decay on the active pass, including the saturating cases.
        run_cycle(1'b0, 32'd0, 32'h1234_5150, 12'h100);
        check_eq("t3_decay", ring_shiftin, 32'h1234_5050);
        run_cycle(1'b0, 32'd0, 32'h1234_5080, 12'h100);
        check_eq("t3_to_zero", ring_shiftin, 32'd0);
        run_cycle(1'b0, 32'd0, 32'h1234_5100, 12'h100);
        check_eq("t3_exact_zero", ring_shiftin, 32'd0);
        run_cycle(1'b0, 32'd0, 32'h1234_5150, 12'h000);
        check_eq("t3_step_zero", ring_shiftin, 32'h1234_5150);

        // Zero-luma pixel is accepted and discarded.
        run_cycle(1'b1, 32'h5555_5000, 32'hABCD_E7FF, 12'd0);
        check_eq("zero_accept", 32'(obs_ready), 32'd1);
        run_cycle(1'b0, 32'd0, 32'd0, 12'd0);
        check_eq("zero_discard", ring_shiftin, 32'd0);

        // Merge: ring luma wins, then held luma wins.
        run_cycle(1'b1, 32'h0040_1300, 32'h1234_5FFF, 12'd0);
        run_cycle(1'b0, 32'd0, 32'h0040_1500, 12'd0);
        check_eq("t4_merge_ready", 32'(obs_ready), 32'd1);
        check_eq("t4_merge_ring", ring_shiftin, 32'h0040_1500);
        run_cycle(1'b1, 32'h0040_1700, 32'h1234_5FFF, 12'd0);
        run_cycle(1'b0, 32'd0, 32'h0040_1500, 12'd0);
        check_eq("t4_merge_hold", ring_shiftin, 32'h0040_1700);

        // Starvation: ring always live, YX differs only in X bit 0.
        run_cycle(1'b1, 32'h0040_1ABC, 32'h0040_0FFF, 12'd0);
        n = 0;
        do begin
            n++;
            run_cycle(1'b0, 32'd0, 32'h0040_0FFF, 12'd0);
        end while (!obs_ready && n < SL + 16);
        check_eq("t5_starve_cycles", 32'(n), 32'(SL + 1));
        check_eq("t5_forced_word", ring_shiftin, 32'h0040_1ABC);
        check_eq("t5_drops", 32'(drop_count), 32'd1);

        // Non-decay pass leaves luma untouched.
        while (model_pass() == 0) run_cycle(1'b0, 32'd0, 32'd0, 12'd0);
        run_cycle(1'b0, 32'd0, 32'h1234_5150, 12'h100);
        check_eq("no_decay_pass", ring_shiftin, 32'h1234_5150);

        // Reset with a pixel held: it must never reach the ring.
        run_cycle(1'b1, 32'h0ABC_D123, 32'h0040_0FFF, 12'd0);
        do_reset();
        repeat (RL) run_cycle(1'b0, 32'd0, $urandom, 12'd0);
        repeat (4) run_cycle(1'b0, 32'd0, 32'd0, 12'd0);
        check_eq("t6_no_held", ring_shiftin, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
